// File: rtl/yuv422_to_rgb_if.sv
// ----------------------------------------------------------------------------
// yuv422_to_rgb_if: sync/qualifier/data bundle for the YUV422 -> RGB converter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface yuv422_to_rgb_if #(
  parameter int X_CNT_WIDTH = 11,
  parameter int Y_CNT_WIDTH = 11
);
  logic                   in_vsync;
  logic                   in_hsync;
  logic                   in_de;
  logic                   in_valid;
  logic [31:0]            in_data;
  logic                   out_vsync;
  logic                   out_hsync;
  logic                   out_de;
  logic                   out_valid;
  logic [47:0]            out_data;
  logic [X_CNT_WIDTH-1:0] out_x;
  logic [Y_CNT_WIDTH-1:0] out_y;

  // master sources the YUV stream and observes the RGB stream
  modport master (
    output in_vsync, in_hsync, in_de, in_valid, in_data,
    input  out_vsync, out_hsync, out_de, out_valid, out_data, out_x, out_y
  );

  modport slave (
    input  in_vsync, in_hsync, in_de, in_valid, in_data,
    output out_vsync, out_hsync, out_de, out_valid, out_data, out_x, out_y
  );
endinterface

`default_nettype wire

// File: rtl/yuv422_to_rgb.sv
// ----------------------------------------------------------------------------
// yuv422_to_rgb: 2-stage BT.709 YUV422 pair -> RGB888 pair converter with x/y
// position counters. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module yuv422_to_rgb #(
  parameter int X_CNT_WIDTH = 11,
  parameter int Y_CNT_WIDTH = 11
) (
  input  wire logic         clk,
  input  wire logic         rst,
  yuv422_to_rgb_if.slave    bus
);

  localparam logic signed [17:0] c_CRV  = 18'sd403;
  localparam logic signed [17:0] c_CGU  = 18'sd48;
  localparam logic signed [17:0] c_CGV  = 18'sd120;
  localparam logic signed [17:0] c_CBU  = 18'sd475;
  localparam logic signed [17:0] c_HALF = 18'sd128;

  function automatic logic [7:0] clamp8(input logic signed [17:0] a);
    if (a[17])      return 8'd0;
    else if (a[16]) return 8'hFF;
    else            return a[15:8];
  endfunction

  // {vsync, hsync, de, valid}; stage-1 copy doubles as the edge-detect history
  logic [3:0] sync1_q, sync2_q;
  logic signed [17:0] r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
  logic signed [17:0] r0_d, g0_d, b0_d, r1_d, g1_d, b1_d;
  logic [X_CNT_WIDTH-1:0] x_cnt_q, x_cnt_d, x1_q, x1_d, x2_q, x_cur;
  logic [Y_CNT_WIDTH-1:0] y_cnt_q, y_cnt_d, y1_q, y1_d, y2_q, y_cur;
  logic [47:0] data2_q;

  logic [7:0] y0, u, y1, v;
  logic signed [17:0] y0_s, y1_s, u_s, v_s, r_off, g_off, b_off;
  logic accept, hs_fall, vs_fall;

  assign y0 = bus.in_data[7:0];
  assign u  = bus.in_data[15:8];
  assign y1 = bus.in_data[23:16];
  assign v  = bus.in_data[31:24];

  assign y0_s  = $signed({2'b00, y0, 8'h00});
  assign y1_s  = $signed({2'b00, y1, 8'h00});
  assign u_s   = $signed({10'd0, u}) - c_HALF;
  assign v_s   = $signed({10'd0, v}) - c_HALF;
  assign r_off = c_CRV * v_s;
  assign g_off = c_CGU * u_s + c_CGV * v_s;
  assign b_off = c_CBU * u_s;

  assign accept  = bus.in_de & bus.in_valid;
  assign hs_fall = sync1_q[2] & ~bus.in_hsync;
  assign vs_fall = sync1_q[3] & ~bus.in_vsync;

  always_comb begin
    r0_d    = r0_q;
    g0_d    = g0_q;
    b0_d    = b0_q;
    r1_d    = r1_q;
    g1_d    = g1_q;
    b1_d    = b1_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    // a pair arriving on the hsync falling edge is the first of the new line
    x_cur   = hs_fall ? '0 : x_cnt_q;
    y_cur   = vs_fall ? '0 : (hs_fall ? y_cnt_q + Y_CNT_WIDTH'(1) : y_cnt_q);
    x_cnt_d = x_cur;
    y_cnt_d = y_cur;
    if (accept) begin
      r0_d    = y0_s + r_off;
      g0_d    = y0_s - g_off;
      b0_d    = y0_s + b_off;
      r1_d    = y1_s + r_off;
      g1_d    = y1_s - g_off;
      b1_d    = y1_s + b_off;
      x1_d    = x_cur;
      y1_d    = y_cur;
      x_cnt_d = x_cur + X_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      r0_q    <= '0;
      g0_q    <= '0;
      b0_q    <= '0;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      data2_q <= '0;
    end else begin
      sync1_q <= {bus.in_vsync, bus.in_hsync, bus.in_de, bus.in_valid};
      sync2_q <= sync1_q;
      r0_q    <= r0_d;
      g0_q    <= g0_d;
      b0_q    <= b0_d;
      r1_q    <= r1_d;
      g1_q    <= g1_d;
      b1_q    <= b1_d;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x1_q;
      y2_q    <= y1_q;
      data2_q <= {clamp8(r1_q), clamp8(g1_q), clamp8(b1_q),
                  clamp8(r0_q), clamp8(g0_q), clamp8(b0_q)};
    end
  end

  assign bus.out_vsync = sync2_q[3];
  assign bus.out_hsync = sync2_q[2];
  assign bus.out_de    = sync2_q[1];
  assign bus.out_valid = sync2_q[0];
  assign bus.out_data  = data2_q;
  assign bus.out_x     = x2_q;
  assign bus.out_y     = y2_q;

endmodule

`default_nettype wire

// File: doc/yuv422_to_rgb.md
YUV422_TO_RGB -- requirements
Module: yuv422_to_rgb

Interface
REQ-001 Parameter X_CNT_WIDTH, default 11: width of out_x.
REQ-002 Parameter Y_CNT_WIDTH, default 11: width of out_y.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_vsync  input  1  frame sync.
REQ-006 in_hsync  input  1  line sync.
REQ-007 in_de  input  1  active-video qualifier.
REQ-008 in_valid  input  1  data-valid qualifier.
REQ-009 in_data  input  32  YUV422 pixel pair: [7:0]=Y0, [15:8]=U, [23:16]=Y1, [31:24]=V.
REQ-010 out_vsync  output  1  in_vsync delayed 2 cycles.
REQ-011 out_hsync  output  1  in_hsync delayed 2 cycles.
REQ-012 out_de  output  1  in_de delayed 2 cycles.
REQ-013 out_valid  output  1  in_valid delayed 2 cycles.
REQ-014 out_data  output  48  RGB888 pair: [23:0]=pixel0 {R[23:16],G[15:8],B[7:0]}, [47:24]=pixel1, same layout.
REQ-015 out_x  output  X_CNT_WIDTH  pair index within line, aligned with out_data.
REQ-016 out_y  output  Y_CNT_WIDTH  line index within frame, aligned with out_data.

Function
REQ-017 Fixed 2-cycle latency, input to output, for sync, qualifiers, data and counters; no backpressure, one pair accepted per cycle.
REQ-018 Both pixels SHALL share U and V; pixel n uses Yn.
REQ-019 Chroma offset: U' = U - 128, V' = V - 128, 9-bit signed.
REQ-020 Coefficients Q8, BT.709 inverse, rounded to nearest: CRV=403, CGU=48, CGV=120, CBU=475.
REQ-021 Stage 1 SHALL register 18-bit signed accumulators: R = Y*256 + CRV*V'; G = Y*256 - CGU*U' - CGV*V'; B = Y*256 + CBU*U'.
REQ-022 Stage 2: arithmetic shift right 8 (floor), clamp to 0 if negative, to 255 if >255, else low 8 bits.
REQ-023 Stage-1 data registers SHALL load only when in_de && in_valid; otherwise hold; stage-2 data follows stage 1 every cycle.
REQ-024 Sync/qualifier pipeline SHALL advance every cycle regardless of in_valid.
REQ-025 x counter: cleared on hsync falling edge (registered hsync=1, current=0); else incremented when in_de && in_valid; first valid pair of a line reports 0.
REQ-026 y counter: cleared on vsync falling edge; else incremented on hsync falling edge; simultaneous vsync and hsync falling SHALL clear y (clear wins).
REQ-027 Counters wrap modulo 2^width without saturation.
REQ-028 Counter values SHALL be delayed so out_x/out_y correspond to the pair on out_data.

Reset
REQ-029 While rst=1 at a clock edge, all pipeline registers, counters and outputs SHALL be 0 the following cycle.
REQ-030 Reset asserted mid-line SHALL discard in-flight pairs; first output after release appears 2 cycles after first accepted input.
REQ-031 Registered sync edge detectors SHALL reset to 0, so no false falling edge is detected on the first cycle after reset.

Verification
REQ-032 Y0=Y1=128, U=V=128, valid -> 2 cycles later out_data = 0x808080_808080.
REQ-033 Y0=0, U=128, V=255 -> pixel0 R=199, G=0 (clamped from -60), B=0.
REQ-034 Y0=255, U=255, V=128 -> pixel0 R=255, G=231, B=255 (clamped from 490).
REQ-035 Line of 4 valid pairs with in_valid gaps, then hsync high/low -> out_x 0,1,2,3 on valid outputs only; out_data holds during gaps; next line out_y increments by 1, out_x restarts at 0.
REQ-036 Vsync falling edge coincident with hsync falling edge -> out_y = 0.
REQ-037 rst pulsed for 1 cycle mid-line -> all outputs 0 the next cycle; x and y restart from 0 after release.
